// File: rtl/upower_mem_pkg.sv
// Shared definitions for the uPOWER data-memory responder: access sizes, FSM states
// and helpers that decode an access size into alignment and lane masks.
package upower_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

  // Byte accesses can never be misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic mis;
    unique case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] data_mask(input logic [1:0] size);
    logic [63:0] m;
    unique case (size)
      SIZE_B:  m = 64'h0000_0000_0000_00ff;
      SIZE_H:  m = 64'h0000_0000_0000_ffff;
      SIZE_W:  m = 64'h0000_0000_ffff_ffff;
      default: m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/upower_lane_merge.sv
// Little-endian byte-lane merge/extract for one 64-bit doubleword. Purely combinational;
// assumes lane is aligned to size so the access never crosses the doubleword.
module upower_lane_merge
  import upower_mem_pkg::*;
(
  input  logic [63:0] old_dword_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  lane_i,
  input  logic [1:0]  size_i,
  output logic [63:0] merged_o,
  output logic [63:0] rdata_o
);

  logic [7:0]  byte_en;
  logic [63:0] wdata_shifted;
  logic [63:0] dword_shifted;

  always_comb begin
    byte_en       = byte_mask(size_i) << lane_i;
    wdata_shifted = wdata_i << {lane_i, 3'b000};
    dword_shifted = old_dword_i >> {lane_i, 3'b000};
    for (int i = 0; i < 8; i++) begin
      merged_o[8*i +: 8] = byte_en[i] ? wdata_shifted[8*i +: 8] : old_dword_i[8*i +: 8];
    end
    rdata_o = dword_shifted & data_mask(size_i);
  end

endmodule

// File: rtl/upower_dmem_responder.sv
// Target end of the core's load/store interface: one request at a time, LATENCY wait
// states, then a held response. Writes and read sampling both land on the edge entering RESP.
module upower_dmem_responder
  import upower_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam int unsigned CntW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] AddrLimit = 64'(DEPTH) * 64'd8;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic [63:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              err_q;
  logic [63:0]       mem_q [DEPTH];

  logic              latch_en;
  logic              commit;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic [63:0]       cur_addr;
  logic [63:0]       cur_wdata;
  logic              cur_err;
  logic [IdxW-1:0]   cur_idx;
  logic [63:0]       merged;
  logic [63:0]       extracted;

  // With LATENCY=0 the commit edge is the accept edge, so the live request is used directly.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_size  = req_size;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_err = (cur_addr >= AddrLimit) || misaligned(cur_size, cur_addr[2:0]);
    cur_idx = cur_addr[3 +: IdxW];
  end

  upower_lane_merge u_lane_merge (
    .old_dword_i (mem_q[cur_idx]),
    .wdata_i     (cur_wdata),
    .lane_i      (cur_addr[2:0]),
    .size_i      (cur_size),
    .merged_o    (merged),
    .rdata_o     (extracted)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          latch_en = 1'b1;
          if (LATENCY == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= (cur_err || cur_we) ? 64'd0 : extracted;
        err_q   <= cur_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is deliberately not reset; a reset during WAIT simply never commits.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_we && !cur_err) begin
      mem_q[cur_idx] <= merged;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
